// File: rtl/lzc_stream.sv
// Multi-cycle leading/trailing zero counter. Scans an N-bit word CHUNK bits per cycle
// behind a valid/ready handshake on both sides. The direction is chosen per word, and
// EARLY_EXIT selects first-hit exit or constant latency.
module lzc_stream #(
   parameter int unsigned N          = 64,
   parameter int unsigned CHUNK      = 16,
   parameter bit          EARLY_EXIT = 1'b1,
   localparam int unsigned C         = N / CHUNK,
   localparam int unsigned CNTW      = $clog2(N + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [N-1:0]    in_data_i,
   input  logic            in_mode_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [CNTW-1:0] out_count_o,
   output logic            out_zero_o,
   output logic            busy_o
);

   localparam int unsigned KW = (C > 1) ? $clog2(C) : 1;

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      data_q;
   logic              mode_q;
   logic [KW-1:0]     k_q;
   logic              hit_q;
   logic [CNTW-1:0]   scan_cnt_q;
   logic [CNTW-1:0]   out_count_q;
   logic              out_zero_q;

   logic [C-1:0][CHUNK-1:0] lead_chunks, trail_chunks;
   logic [CHUNK-1:0]  chunk, chunk_rev, scan_bits;
   logic [CNTW-1:0]   local_cnt, scan_cnt, res_cnt;
   logic              chunk_nz, hit_now, last, go_done, accept, load_out, res_zero;

   // Chunk k as seen from the scan origin (MSB side for leading, LSB side for trailing).
   for (genvar c = 0; c < C; c++) begin : g_chunk
      assign trail_chunks[c] = data_q[c*CHUNK +: CHUNK];
      assign lead_chunks[c]  = data_q[N-1-c*CHUNK -: CHUNK];
   end

   // Reversing the leading chunk lets one trailing-zero counter serve both modes.
   for (genvar b = 0; b < CHUNK; b++) begin : g_rev
      assign chunk_rev[b] = chunk[CHUNK-1-b];
   end

   assign chunk     = mode_q ? trail_chunks[k_q] : lead_chunks[k_q];
   assign scan_bits = mode_q ? chunk : chunk_rev;
   assign chunk_nz  = |chunk;

   // In-chunk zero count: index of the lowest set bit of scan_bits.
   always_comb begin
      local_cnt = '0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (scan_bits[i]) begin
            local_cnt = CNTW'(i);
         end
      end
   end

   // Scan decisions for the current chunk; k*CHUNK + local count stays below N on a hit.
   always_comb begin
      scan_cnt = CNTW'(k_q) * CNTW'(CHUNK) + local_cnt;
      hit_now  = chunk_nz && !hit_q;
      last     = (k_q == KW'(C - 1));
      go_done  = (hit_now && EARLY_EXIT) || last;
      res_zero = !hit_now && !hit_q;
      if (hit_now) begin
         res_cnt = scan_cnt;
      end else if (hit_q) begin
         res_cnt = scan_cnt_q;
      end else begin
         res_cnt = CNTW'(N);
      end
      load_out = (state_q == StScan) && !clear_i && go_done;
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; clear_i overrides every transition.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StScan;
         StScan: begin
            if (clear_i) begin
               state_d = StIdle;
            end else if (go_done) begin
               state_d = StDone;
            end
         end
         StDone: if (clear_i || out_ready_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Handshake and status outputs.
   always_comb begin
      in_ready_o  = (state_q == StIdle) && !clear_i;
      out_valid_o = (state_q == StDone);
      busy_o      = (state_q != StIdle);
      accept      = in_valid_i && in_ready_o;
      out_count_o = out_count_q;
      out_zero_o  = out_zero_q;
   end

   // Datapath: word capture, chunk index, first-hit record and registered result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q      <= '0;
         mode_q      <= 1'b0;
         k_q         <= '0;
         hit_q       <= 1'b0;
         scan_cnt_q  <= '0;
         out_count_q <= '0;
         out_zero_q  <= 1'b0;
      end else begin
         if (accept) begin
            data_q <= in_data_i;
            mode_q <= in_mode_i;
            k_q    <= '0;
            hit_q  <= 1'b0;
         end else if ((state_q == StScan) && !clear_i) begin
            if (hit_now) begin
               hit_q      <= 1'b1;
               scan_cnt_q <= scan_cnt;
            end
            if (!last) begin
               k_q <= k_q + KW'(1);
            end
         end
         // Result only changes when a scan completes, so it holds across the handshake.
         if (load_out) begin
            out_count_q <= res_cnt;
            out_zero_q  <= res_zero;
         end
      end
   end

endmodule

// File: tb/tb_lzc_stream.sv
// Directed bench for lzc_stream: one DUT with early exit, one with constant latency.
module tb_lzc_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_valid_ne = 1'b0;
   logic        in_mode = 1'b0;
   logic        out_ready = 1'b1;
   logic [63:0] in_data = '0;

   logic       ready, valid, zero, busy;
   logic [6:0] count;
   logic       ready_ne, valid_ne, zero_ne, busy_ne;
   logic [6:0] count_ne;

   int n_cmp = 0;
   int n_fail = 0;

   lzc_stream #(.N(64), .CHUNK(16), .EARLY_EXIT(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .in_valid_i(in_valid), .in_ready_o(ready), .in_data_i(in_data), .in_mode_i(in_mode),
      .out_valid_o(valid), .out_ready_i(out_ready), .out_count_o(count),
      .out_zero_o(zero), .busy_o(busy)
   );

   lzc_stream #(.N(64), .CHUNK(16), .EARLY_EXIT(1'b0)) dut_ne (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .in_valid_i(in_valid_ne), .in_ready_o(ready_ne), .in_data_i(in_data),
      .in_mode_i(in_mode), .out_valid_o(valid_ne), .out_ready_i(out_ready),
      .out_count_o(count_ne), .out_zero_o(zero_ne), .busy_o(busy_ne)
   );

   always #5 clk = ~clk;

   // Drives one word at a negedge, returns latency in edges from the accept edge to the
   // edge that sees out_valid high (0 on timeout), and completes the handshake.
   task automatic run_word(input bit ne, input logic [63:0] d, input logic m,
                           output int lat, output logic [6:0] cnt, output logic z);
      in_data = d;
      in_mode = m;
      if (ne) in_valid_ne = 1'b1;
      else in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_valid_ne = 1'b0;
      lat = 0;
      cnt = '0;
      z = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if ((ne ? valid_ne : valid) === 1'b1) begin
            lat = i;
            cnt = ne ? count_ne : count;
            z = ne ? zero_ne : zero;
            break;
         end
         @(negedge clk);
      end
      if (lat != 0) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
      n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_cmp++; if (count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_cmp++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b expected 0", zero); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_leading();
      int lat; logic [6:0] cnt; logic z;
      run_word(1'b0, 64'h0000_0000_0001_0000, 1'b0, lat, cnt, z);
      n_cmp++; if (cnt !== 7'd47) begin n_fail++; $display("FAIL lead_count: got %0d expected 47", cnt); end
      n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL lead_zero: got %b expected 0", z); end
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL lead_latency: got %0d expected 4", lat); end
      n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL lead_ready_after: got %b expected 1", ready); end
      n_cmp++; if (count !== 7'd47) begin n_fail++; $display("FAIL lead_count_hold: got %0d expected 47", count); end
   endtask

   task automatic test_trailing();
      int lat; logic [6:0] cnt; logic z;
      run_word(1'b0, 64'h0000_0000_0001_0000, 1'b1, lat, cnt, z);
      n_cmp++; if (cnt !== 7'd16) begin n_fail++; $display("FAIL trail_count: got %0d expected 16", cnt); end
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL trail_latency: got %0d expected 3", lat); end
      run_word(1'b1, 64'h0000_0000_0001_0000, 1'b1, lat, cnt, z);
      n_cmp++; if (cnt !== 7'd16) begin n_fail++; $display("FAIL trail_ne_count: got %0d expected 16", cnt); end
      n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL trail_ne_latency: got %0d expected 5", lat); end
      // Later non-zero chunk must not override the first hit.
      run_word(1'b1, 64'h8000_0000_0000_0001, 1'b1, lat, cnt, z);
      n_cmp++; if (cnt !== 7'd0) begin n_fail++; $display("FAIL trail_ne_first_hit: got %0d expected 0", cnt); end
      n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL trail_ne_zero: got %b expected 0", z); end
      n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL trail_ne_latency2: got %0d expected 5", lat); end
   endtask

   task automatic test_all_zero();
      int lat; logic [6:0] cnt; logic z;
      for (int m = 0; m < 2; m++) begin
         run_word(1'b0, 64'h0, m[0], lat, cnt, z);
         n_cmp++; if (cnt !== 7'd64) begin n_fail++; $display("FAIL zero_count m=%0d: got %0d expected 64", m, cnt); end
         n_cmp++; if (z !== 1'b1) begin n_fail++; $display("FAIL zero_flag m=%0d: got %b expected 1", m, z); end
         n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL zero_latency m=%0d: got %0d expected 5", m, lat); end
      end
      for (int m = 0; m < 2; m++) begin
         run_word(1'b0, 64'h8000_0000_0000_0001, m[0], lat, cnt, z);
         n_cmp++; if (cnt !== 7'd0) begin n_fail++; $display("FAIL edge_count m=%0d: got %0d expected 0", m, cnt); end
         n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL edge_zero m=%0d: got %b expected 0", m, z); end
         n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL edge_latency m=%0d: got %0d expected 2", m, lat); end
      end
   endtask

   task automatic test_backpressure();
      bit got;
      out_ready = 1'b0;
      in_data = 64'h0000_0000_0001_0000;
      in_mode = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (valid === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout: got %b expected 1", got); end
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data = 64'h0;
         in_mode = 1'b1;
         #1;
         n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c=%0d: got %b expected 1", c, valid); end
         n_cmp++; if (count !== 7'd47) begin n_fail++; $display("FAIL bp_count c=%0d: got %0d expected 47", c, count); end
         n_cmp++; if (zero !== 1'b0) begin n_fail++; $display("FAIL bp_zero c=%0d: got %b expected 0", c, zero); end
         n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready c=%0d: got %b expected 0", c, ready); end
         n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy c=%0d: got %b expected 1", c, busy); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b expected 1", ready); end
      n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after: got %b expected 0", valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_after: got %b expected 0", busy); end
      n_cmp++; if (count !== 7'd47) begin n_fail++; $display("FAIL bp_count_after: got %0d expected 47", count); end
   endtask

   task automatic test_clear();
      int lat; logic [6:0] cnt; logic z; bit seen; bit got;
      in_data = 64'h0;
      in_mode = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b expected 0", busy); end
      n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready: got %b expected 1", ready); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL clr_no_valid: got %b expected 0", seen); end
      // A word offered together with clear must be refused.
      clear = 1'b1;
      in_valid = 1'b1;
      in_data = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_forced: got %b expected 0", ready); end
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      in_valid = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_not_accepted: got %b expected 0", busy); end
      run_word(1'b0, 64'h1, 1'b1, lat, cnt, z);
      n_cmp++; if (cnt !== 7'd0) begin n_fail++; $display("FAIL clr_next_count: got %0d expected 0", cnt); end
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL clr_next_latency: got %0d expected 2", lat); end
      // Clear while holding a result in DONE discards it.
      out_ready = 1'b0;
      in_data = 64'h1;
      in_mode = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (valid === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL clr_done_timeout: got %b expected 1", got); end
      n_cmp++; if (count !== 7'd63) begin n_fail++; $display("FAIL clr_done_count: got %0d expected 63", count); end
      clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL clr_done_valid: got %b expected 0", valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_done_busy: got %b expected 0", busy); end
      out_ready = 1'b1;
   endtask

   task automatic test_async_reset();
      int lat; logic [6:0] cnt; logic z; bit got;
      // Mid-scan: count still holds 63 from the discarded-then-kept result register.
      in_data = 64'h0;
      in_mode = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_scan_busy: got %b expected 0", busy); end
      n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_scan_ready: got %b expected 1", ready); end
      n_cmp++; if (count !== 7'd0) begin n_fail++; $display("FAIL rst_scan_count: got %0d expected 0", count); end
      @(negedge clk);
      rst_n = 1'b1;
      // Mid-DONE.
      out_ready = 1'b0;
      in_data = 64'h1;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (valid === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      n_cmp++; if (got !== 1'b1) begin n_fail++; $display("FAIL rst_done_timeout: got %b expected 1", got); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_done_valid: got %b expected 0", valid); end
      n_cmp++; if (count !== 7'd0) begin n_fail++; $display("FAIL rst_done_count: got %0d expected 0", count); end
      n_cmp++; if (zero !== 1'b0) begin n_fail++; $display("FAIL rst_done_zero: got %b expected 0", zero); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_done_busy: got %b expected 0", busy); end
      n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_done_ready: got %b expected 1", ready); end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      run_word(1'b0, 64'h0000_0000_0001_0000, 1'b0, lat, cnt, z);
      n_cmp++; if (cnt !== 7'd47) begin n_fail++; $display("FAIL rst_after_count: got %0d expected 47", cnt); end
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL rst_after_latency: got %0d expected 4", lat); end
   endtask

   initial begin
      test_reset();
      test_leading();
      test_trailing();
      test_all_zero();
      test_backpressure();
      test_clear();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
